// File: rtl/srl_chain_checker.sv
// Multi-channel shift-register self-checker: no-reset delay chains (SRL candidates)
// fed by one LFSR, each compared at a dynamic tap and its cascade output against a reset flop history.
module srl_chain_checker #(
  parameter int          NUM_CH = 8,
  parameter int          DEPTH  = 32,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] tap,
  input  logic [NUM_CH-1:0]        inject_err,
  output logic [NUM_CH-1:0]        error,
  output logic                     any_error,
  output logic                     checking,
  output logic [15:0]              err_cnt
);

  localparam int AW = $clog2(DEPTH);

  // state | meaning
  // FILL  | flushing stale chain contents, compares suppressed
  // CHECK | chains full, compare every cycle
  typedef enum logic {FILL, CHECK} state_t;

  state_t              state, state_next;
  logic [AW-1:0]       fill_cnt, fill_cnt_next;
  logic [AW-1:0]       tap_q;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic [DEPTH-1:0]    hist;
  logic [NUM_CH-1:0]   mis, mis_chk;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
      hist <= '0;
    end else begin
      if (lfsr == 16'd0)
        lfsr <= 16'd1;
      else if (en)
        lfsr <= {lfsr_fb, lfsr[15:1]};
      if (en)
        hist <= {hist[DEPTH-2:0], lfsr[0]};
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DEPTH-1:0] chain;
    logic [AW-1:0]    tap_c;
    logic             inj;

    assign inj   = inject_err[g] & (state == CHECK);
    assign tap_c = tap_q + AW'(g);

    // No reset here on purpose, so the chain can map onto SRL primitives
    always_ff @(posedge clk) begin
      if (en)
        chain <= {chain[DEPTH-2:0], lfsr[0] ^ inj};
    end

    assign mis[g] = (chain[tap_c] != hist[tap_c]) | (chain[DEPTH-1] != hist[DEPTH-1]);
  end

  assign mis_chk  = (state == CHECK) ? mis : '0;
  assign checking = (state == CHECK);

  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    case (state)
      FILL: begin
        if (en) begin
          fill_cnt_next = fill_cnt + 1'b1;
          if (fill_cnt == AW'(DEPTH - 1))
            state_next = CHECK;
        end
      end
      CHECK: state_next = CHECK;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      tap_q     <= '0;
      error     <= '0;
      any_error <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_next;
      fill_cnt  <= fill_cnt_next;
      tap_q     <= tap;
      error     <= error | mis_chk;
      any_error <= |(error | mis_chk);
      if ((|mis_chk) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_srl_chain_checker.sv
// Directed self-checking bench for srl_chain_checker (NUM_CH=8, DEPTH=32).
module tb_srl_chain_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  tap;
  logic [7:0]  inject_err;
  logic [7:0]  error;
  logic        any_error;
  logic        checking;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  srl_chain_checker #(.NUM_CH(8), .DEPTH(32), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tap        (tap),
    .inject_err (inject_err),
    .error      (error),
    .any_error  (any_error),
    .checking   (checking),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // leaves time at 1 unit after the n-th rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic refill(input string tag);
    int cnt;
    cnt = 0;
    en = 1'b1;
    while (!checking && cnt < 100) begin
      step(1);
      cnt++;
    end
    chk(tag, {31'd0, checking}, 32'd1);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seen;
    rst = 1'b1; en = 1'b0; tap = '0; inject_err = '0;
    step(3);
    chk("rst_error",     {24'd0, error},      32'h0);
    chk("rst_any",       {31'd0, any_error},  32'h0);
    chk("rst_checking",  {31'd0, checking},   32'h0);
    chk("rst_err_cnt",   {16'd0, err_cnt},    32'h0);

    // 1: fill takes exactly 32 shifts, then clean run
    rst = 1'b0; en = 1'b1;
    step(31);
    chk("t1_fill31", {31'd0, checking}, 32'd0);
    step(1);
    chk("t1_fill32", {31'd0, checking}, 32'd1);
    seen = '0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      seen |= error;
    end
    chk("t1_no_err", {24'd0, seen}, 32'h0);
    chk("t1_cnt",    {16'd0, err_cnt}, 32'h0);

    // 2: tap=5, channel 2 taps position 7
    tap = 5'd5;
    step(2);
    inject_err = 8'h04;
    step(1);
    inject_err = 8'h00;
    step(7);
    chk("t2_err_e7",  {24'd0, error}, 32'h00);
    step(1);
    chk("t2_err_e8",  {24'd0, error}, 32'h04);
    chk("t2_cnt_e8",  {16'd0, err_cnt}, 32'd1);
    chk("t2_any_e8",  {31'd0, any_error}, 32'd1);
    step(23);
    chk("t2_cnt_e31", {16'd0, err_cnt}, 32'd1);
    step(1);
    chk("t2_cnt_e32", {16'd0, err_cnt}, 32'd2);
    chk("t2_err_e32", {24'd0, error}, 32'h04);

    // 3: random enable, stepped taps
    hard_reset();
    refill("t3_refill");
    seen = '0;
    for (int t = 0; t < 32; t++) begin
      tap = 5'(t);
      for (int c = 0; c < 40; c++) begin
        en = 1'($urandom_range(0, 1));
        step(1);
        seen |= error;
      end
    end
    en = 1'b1;
    chk("t3_no_err", {24'd0, seen}, 32'h0);
    chk("t3_cnt",    {16'd0, err_cnt}, 32'h0);

    // 4: async reset between edges while errors are set
    tap = 5'd0;
    step(2);
    inject_err = 8'h01;
    step(1);
    inject_err = 8'h00;
    step(1);
    chk("t4_pre_err", {24'd0, error}, 32'h01);
    #3;
    rst = 1'b1;
    #1;
    chk("t4_async_err",  {24'd0, error},     32'h0);
    chk("t4_async_chk",  {31'd0, checking},  32'd0);
    chk("t4_async_cnt",  {16'd0, err_cnt},   32'h0);
    chk("t4_async_any",  {31'd0, any_error}, 32'd0);
    #1;
    rst = 1'b0;
    step(31);
    chk("t4_fill31", {31'd0, checking}, 32'd0);
    step(1);
    chk("t4_fill32", {31'd0, checking}, 32'd1);
    seen = '0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      seen |= error;
    end
    chk("t4_no_stale", {24'd0, seen}, 32'h0);
    chk("t4_cnt",      {16'd0, err_cnt}, 32'h0);

    // 5: tap=31, channel 1 wraps to position 0
    tap = 5'd31;
    step(2);
    inject_err = 8'h02;
    step(1);
    inject_err = 8'h00;
    chk("t5_err_e0",  {24'd0, error}, 32'h00);
    step(1);
    chk("t5_err_e1",  {24'd0, error}, 32'h02);
    chk("t5_cnt_e1",  {16'd0, err_cnt}, 32'd1);
    step(30);
    chk("t5_cnt_e31", {16'd0, err_cnt}, 32'd1);
    step(1);
    chk("t5_cnt_e32", {16'd0, err_cnt}, 32'd2);

    // 6: inject then stall; inject held high while en=0 has no effect
    hard_reset();
    refill("t6_refill");
    tap = 5'd3;
    step(2);
    inject_err = 8'h01;
    step(1);
    en = 1'b0;
    step(20);
    chk("t6_stall_err", {24'd0, error}, 32'h0);
    chk("t6_stall_cnt", {16'd0, err_cnt}, 32'h0);
    inject_err = 8'h00;
    en = 1'b1;
    step(3);
    chk("t6_en3_err", {24'd0, error}, 32'h0);
    step(1);
    chk("t6_en4_err", {24'd0, error}, 32'h01);
    chk("t6_en4_cnt", {16'd0, err_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
